// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and load-queue entry type for the writeback unit
package wb_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_unit_if.sv
// rtl/regfile_writeback_unit_if.sv - ALU/load inputs, forwarding lookups and register-file write port
interface regfile_writeback_unit_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_fwd_hit;
  logic [XLEN-1:0] rs1_fwd_data;
  logic            rs2_fwd_hit;
  logic [XLEN-1:0] rs2_fwd_data;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [CW-1:0]   q_count;

  modport master (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1_addr, rs2_addr,
    output ld_ready, rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data,
           rd_addr, rd_data, q_count
  );

  modport slave (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1_addr, rs2_addr,
    input  ld_ready, rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data,
           rd_addr, rd_data, q_count
  );
endinterface

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - in-order load result buffer with WAW kill and youngest-match lookup
module wb_load_queue
  import wb_pkg::wb_entry_t;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int AW    = wb_pkg::AW,
  parameter int DEPTH = wb_pkg::DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  logic [AW-1:0]   enq_rd,
  input  logic [XLEN-1:0] enq_data,
  input  logic            kill_en,
  input  logic [AW-1:0]   kill_rd,
  input  logic            pop,
  output wb_entry_t       head,
  output logic            full,
  output logic [CW-1:0]   count,
  input  logic [AW-1:0]   lk_addr [2],
  output logic            lk_hit  [2],
  output logic [XLEN-1:0] lk_data [2]
);
  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   hd;
  logic [PW-1:0]   tl;
  logic [PW-1:0]   idx;
  logic            do_enq;
  logic            do_pop;

  assign full   = (count == CW'(DEPTH));
  assign head   = mem[hd];
  assign do_enq = enq && !full;
  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
      end
      // The load is older than a same-cycle ALU write, so it arrives already killed.
      if (do_enq) begin
        mem[tl] <= '{!(kill_en && kill_rd == enq_rd), enq_rd, enq_data};
        tl      <= tl + 1'b1;
      end
      if (do_pop) hd <= hd + 1'b1;
      count <= count + CW'(do_enq) - CW'(do_pop);
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    idx = '0;
    for (int l = 0; l < 2; l++) begin
      lk_hit[l]  = 1'b0;
      lk_data[l] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = hd + PW'(i);
        if (CW'(i) < count && mem[idx].valid && lk_addr[l] != '0 && mem[idx].rd == lk_addr[l]) begin
          lk_hit[l]  = 1'b1;
          lk_data[l] = mem[idx].data;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_writeback_unit.sv
// rtl/regfile_writeback_unit.sv - merges ALU and load results into one register-file write port
module regfile_writeback_unit
  import wb_pkg::wb_entry_t;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int AW    = wb_pkg::AW,
  parameter int DEPTH = wb_pkg::DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_writeback_unit_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t       head;
  logic            q_full;
  logic [CW-1:0]   q_cnt;
  logic            alu_wr;
  logic            head_wr;
  logic            enq;
  logic            pop;
  logic [AW-1:0]   lk_addr [2];
  logic            lk_hit  [2];
  logic [XLEN-1:0] lk_data [2];

  assign alu_wr  = bus.alu_valid && bus.alu_rd != '0;
  assign head_wr = (q_cnt != '0) && head.valid;
  // A killed head leaves regardless of ALU traffic; a live head waits for a free slot.
  assign pop     = (q_cnt != '0) && (!head.valid || !alu_wr);
  assign enq     = bus.ld_valid && !q_full && bus.ld_rd != '0;

  assign bus.ld_ready = !q_full;
  assign bus.q_count  = q_cnt;
  assign lk_addr[0]   = bus.rs1_addr;
  assign lk_addr[1]   = bus.rs2_addr;

  wb_load_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq),
    .enq_rd   (bus.ld_rd),
    .enq_data (bus.ld_data),
    .kill_en  (alu_wr),
    .kill_rd  (bus.alu_rd),
    .pop      (pop),
    .head     (head),
    .full     (q_full),
    .count    (q_cnt),
    .lk_addr  (lk_addr),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_addr <= '0;
      bus.rd_data <= '0;
    end else if (alu_wr) begin
      bus.rd_addr <= bus.alu_rd;
      bus.rd_data <= bus.alu_data;
    end else if (head_wr) begin
      bus.rd_addr <= head.rd;
      bus.rd_data <= head.data;
    end else begin
      bus.rd_addr <= '0;
    end
  end

  always_comb begin
    bus.rs1_fwd_hit  = 1'b0;
    bus.rs1_fwd_data = '0;
    if (bus.rs1_addr != '0) begin
      if (alu_wr && bus.alu_rd == bus.rs1_addr) begin
        bus.rs1_fwd_hit  = 1'b1;
        bus.rs1_fwd_data = bus.alu_data;
      end else if (bus.rd_addr == bus.rs1_addr) begin
        bus.rs1_fwd_hit  = 1'b1;
        bus.rs1_fwd_data = bus.rd_data;
      end else if (lk_hit[0]) begin
        bus.rs1_fwd_hit  = 1'b1;
        bus.rs1_fwd_data = lk_data[0];
      end
    end
  end

  always_comb begin
    bus.rs2_fwd_hit  = 1'b0;
    bus.rs2_fwd_data = '0;
    if (bus.rs2_addr != '0) begin
      if (alu_wr && bus.alu_rd == bus.rs2_addr) begin
        bus.rs2_fwd_hit  = 1'b1;
        bus.rs2_fwd_data = bus.alu_data;
      end else if (bus.rd_addr == bus.rs2_addr) begin
        bus.rs2_fwd_hit  = 1'b1;
        bus.rs2_fwd_data = bus.rd_data;
      end else if (lk_hit[1]) begin
        bus.rs2_fwd_hit  = 1'b1;
        bus.rs2_fwd_data = lk_data[1];
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb/tb_regfile_writeback_unit.sv - scoreboard bench for regfile_writeback_unit
module tb_regfile_writeback_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [35:0] exp_q[$];
  logic [35:0] e;

  regfile_writeback_unit_if #(.XLEN(32), .AW(4), .DEPTH(4)) bus ();

  regfile_writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic alu(input logic v, input logic [3:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
    if (v && rd != 4'd0) exp_q.push_back({rd, d});
  endtask

  task automatic ld(input logic v, input logic [3:0] rd, input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  // Every register-file write must be the next expected one.
  always @(negedge clk) begin
    if (bus.rd_addr != 4'd0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got rd=%0d data=%h expected no write", bus.rd_addr, bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rd_addr, bus.rd_data} !== e) begin
          n_bad++;
          $display("FAIL wr_order: got rd=%0d data=%h expected rd=%0d data=%h",
                   bus.rd_addr, bus.rd_data, e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu(1'b0, 4'd0, 32'h0);
    ld(1'b0, 4'd0, 32'h0);
    bus.rs1_addr = 4'd0;
    bus.rs2_addr = 4'd0;
    step();
    step();
    rst = 1'b0;
    step();

    bus.rs1_addr = 4'd5;
    bus.rs2_addr = 4'd7;
    #1;
    chk("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("reset_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("reset_q_count", 32'(bus.q_count), 32'd0);
    chk("reset_rs1_hit", 32'(bus.rs1_fwd_hit), 32'd0);
    chk("reset_rs2_hit", 32'(bus.rs2_fwd_hit), 32'd0);

    alu(1'b1, 4'd5, 32'hA5A5A5A5);
    #1;
    chk("fwd_alu_hit", 32'(bus.rs1_fwd_hit), 32'd1);
    chk("fwd_alu_data", bus.rs1_fwd_data, 32'hA5A5A5A5);
    step();
    alu(1'b0, 4'd0, 32'h0);
    #1;
    chk("fwd_outreg_hit", 32'(bus.rs1_fwd_hit), 32'd1);
    chk("fwd_outreg_data", bus.rs1_fwd_data, 32'hA5A5A5A5);
    step();
    chk("fwd_after_write_hit", 32'(bus.rs1_fwd_hit), 32'd0);

    for (int k = 0; k < 4; k++) begin
      alu(1'b1, 4'(k + 1), 32'h100 + 32'(k));
      ld(1'b1, 4'(k + 6), 32'h200 + 32'(k));
      #1;
      chk("fill_ld_ready", 32'(bus.ld_ready), 32'd1);
      step();
    end
    alu(1'b1, 4'd1, 32'h104);
    ld(1'b1, 4'd10, 32'h20A);
    #1;
    chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("full_q_count", 32'(bus.q_count), 32'd4);
    step();
    chk("full_hold_q_count", 32'(bus.q_count), 32'd4);
    alu(1'b0, 4'd0, 32'h0);
    ld(1'b0, 4'd0, 32'h0);
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(k + 6), 32'h200 + 32'(k)});
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_q_count", 32'(bus.q_count), 32'(3 - k));
    end
    chk("drain_ld_ready", 32'(bus.ld_ready), 32'd1);
    step();

    alu(1'b1, 4'd1, 32'h300);
    ld(1'b1, 4'd7, 32'h11);
    step();
    chk("kill_q_count_pre", 32'(bus.q_count), 32'd1);
    alu(1'b1, 4'd7, 32'h22);
    ld(1'b0, 4'd0, 32'h0);
    bus.rs2_addr = 4'd7;
    #1;
    chk("kill_fwd_alu_data", bus.rs2_fwd_data, 32'h22);
    step();
    alu(1'b0, 4'd0, 32'h0);
    #1;
    chk("kill_head_q_count", 32'(bus.q_count), 32'd1);
    chk("kill_fwd_outreg_data", bus.rs2_fwd_data, 32'h22);
    step();
    chk("kill_popped_q_count", 32'(bus.q_count), 32'd0);
    chk("kill_no_fwd", 32'(bus.rs2_fwd_hit), 32'd0);
    step();

    bus.rs1_addr = 4'd3;
    alu(1'b1, 4'd3, 32'h33);
    ld(1'b1, 4'd3, 32'h44);
    step();
    alu(1'b0, 4'd0, 32'h0);
    ld(1'b0, 4'd0, 32'h0);
    #1;
    chk("same_cycle_q_count", 32'(bus.q_count), 32'd1);
    chk("same_cycle_fwd_data", bus.rs1_fwd_data, 32'h33);
    step();
    chk("same_cycle_popped", 32'(bus.q_count), 32'd0);
    chk("same_cycle_no_fwd", 32'(bus.rs1_fwd_hit), 32'd0);

    for (int k = 0; k < 3; k++) begin
      alu(1'b1, 4'd1, 32'h400 + 32'(k));
      ld(1'b1, 4'(k + 10), 32'h500 + 32'(k));
      step();
    end
    alu(1'b0, 4'd0, 32'h0);
    ld(1'b0, 4'd0, 32'h0);
    rst = 1'b1;
    chk("prereset_q_count", 32'(bus.q_count), 32'd3);
    step();
    rst = 1'b0;
    chk("midreset_q_count", 32'(bus.q_count), 32'd0);
    chk("midreset_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("midreset_ld_ready", 32'(bus.ld_ready), 32'd1);

    ld(1'b1, 4'd0, 32'h99);
    step();
    ld(1'b0, 4'd0, 32'h0);
    chk("rd0_load_dropped", 32'(bus.q_count), 32'd0);
    for (int k = 0; k < 4; k++) step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
- Write-side master for the 32-bit, 16-address register file.
- Merges the ALU result stream and the variable-latency load result stream into the file's single write port (rd_addr/rd_data), one write per cycle.
- Load results that collide with ALU writes are buffered in a small in-order queue.
- Provides rs1/rs2 forwarding of any write not yet visible in the register file.

Parameters:
- XLEN, 32, data width.
- AW, 4, register address width.
- DEPTH, 4, load queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present this cycle (always accepted)
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  queue can accept a load result
- ld_rd  in  AW  load destination
- ld_data  in  XLEN  load data
- rs1_addr  in  AW  forwarding lookup 1
- rs2_addr  in  AW  forwarding lookup 2
- rs1_fwd_hit  out  1  forwarding hit for rs1
- rs1_fwd_data  out  XLEN  forwarded value for rs1
- rs2_fwd_hit  out  1  forwarding hit for rs2
- rs2_fwd_data  out  XLEN  forwarded value for rs2
- rd_addr  out  AW  register-file write address (0 = no write)
- rd_data  out  XLEN  register-file write data
- q_count  out  $clog2(DEPTH)+1  occupied queue entries, valid and killed

Behaviour:
- Reset (rst high at a clk edge):
  - rd_addr=0, rd_data=0, queue emptied, q_count=0.
  - Any mid-operation content is discarded; there is no partial drain.
- Output stage: rd_addr/rd_data are registered, so a write reaches the register file 1 cycle after selection and lands in the file at the edge after that.
- Selection each cycle, in priority order:
  - (a) alu_valid && alu_rd!=0 → the output register takes the ALU result.
  - (b) otherwise, a valid queue head → the output register takes the head and pops it.
  - (c) otherwise → rd_addr <= 0 and rd_data holds its previous value.
  - alu_valid with alu_rd==0 counts as no write and does not block the drain.
- Load handshake:
  - Transfer occurs when ld_valid && ld_ready.
  - ld_ready = (q_count < DEPTH), depending on state only; there is no same-cycle pop credit when full.
  - A transfer with ld_rd==0 is accepted and dropped, not enqueued.
  - ld_valid may stay high across stalls; data must remain stable until the transfer.
- WAW kill:
  - An ALU write to register X clears the valid bit of every queued entry with rd X.
  - This includes an entry being enqueued in the same cycle, since the load is older.
  - A killed entry at the head is popped in any cycle, at one per cycle, and produces no write. Its pop may coincide with an ALU write.
- Forwarding (combinational; per lookup, addr 0 never hits), in priority order:
  - (1) the current ALU input when alu_valid && alu_rd==addr;
  - (2) the output register when rd_addr==addr;
  - (3) the youngest valid queue entry with matching rd;
  - (4) otherwise hit=0 and data=0.
- Queue pointers wrap modulo DEPTH. Simultaneous enqueue and pop leave q_count unchanged.
- Invariant: writes to any single register reach rd_addr in program order. A value older than one already written is never written.

Decomposition:
- Package wb_pkg: XLEN, AW, DEPTH defaults and the queue-entry struct type {valid, rd[AW], data[XLEN]}.
- One sub-module, wb_load_queue: circular buffer holding entries, pointers, count, kill-by-address, head pop and youngest-match search. Its outputs are the head entry, full, count and per-lookup match.
- The top level holds the selection mux, the output register and the forwarding priority.

Test Plan:
- Reset, then idle → rd_addr=0, ld_ready=1, q_count=0, both fwd_hit=0.
- ALU rd=5 data=0xA5A5A5A5 on cycle N → rd_addr=5, rd_data=0xA5A5A5A5 on N+1; rs1_addr=5 hits in cycle N (ALU) and cycle N+1 (output register).
- ALU busy (rd=1,2,3,4) while loads rd=6..9 arrive with ld_valid high every cycle:
  - 4 loads are accepted, then ld_ready=0;
  - on ALU idle, 6,7,8,9 drain in order at one per cycle, then ld_ready returns to 1.
- Load rd=7 data=0x11 queued behind ALU traffic, then ALU rd=7 data=0x22 → 0x11 is never written; the 0x22 write occurs, q_count drops when the killed head pops, and rs2_addr=7 forwards 0x22.
- Same cycle: ALU rd=3 and load rd=3 → the load is killed on enqueue; only the ALU write appears.
- Queue holding 3 entries, rst asserted for 1 cycle → next cycle q_count=0, rd_addr=0, and no further writes appear.
